// File: rtl/ppt_pkg.sv
// Shared types and constants for the PPT pulse controller.
// Imported by the prescaler and the controller top.
package ppt_pkg;

    localparam int PRESC_W_DEF = 32;
    localparam int CNT_W       = 16;
    localparam int DIV_W       = 5;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/ppt_prescaler.sv
// Free-running tick prescaler.
// Emits a one-cycle tick every 2^(k+1) clocks, where k is div clamped to PRESC_W-2.
module ppt_prescaler
    import ppt_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam int KMAX = PRESC_W - 2;

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] mask;
    logic [PRESC_W-1:0] ones;
    int                 k;

    always_comb begin
        k    = (int'(div) > KMAX) ? KMAX : int'(div);
        ones = '1;
        mask = ones >> (PRESC_W - 1 - k);
        tick = ((presc & mask) == mask);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/ppt_pulse_controller.sv
// Burst pulse generator for the PPT driver.
// Fires count pulses of width ticks every period ticks; config is latched at start.
module ppt_pulse_controller
    import ppt_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] count,
    input  logic             run_ppt,
    output logic             fire,
    output logic             busy,
    output logic [CNT_W-1:0] count_done,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_lat;
    logic [CNT_W-1:0] period_lat;
    logic [CNT_W-1:0] width_lat;
    logic [CNT_W-1:0] count_lat;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] width_eff;
    logic             tick;
    logic             cfg_ok;
    logic             pulse_end;
    logic             gap_end;
    logic             last_pulse;

    logic             latch;
    logic             clr;
    logic             fire_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [CNT_W-1:0] cd_nxt;
    logic [CNT_W-1:0] tc_nxt;

    ppt_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .div  (div_lat),
        .tick (tick)
    );

    always_comb begin
        cfg_ok     = (period >= CNT_W'(2)) && (width != '0) && (count != '0);
        width_eff  = (width_lat >= period_lat) ? period_lat - CNT_W'(1)
                                               : width_lat;
        pulse_end  = tick && (tick_cnt == width_eff - CNT_W'(1));
        gap_end    = tick && (tick_cnt == period_lat - CNT_W'(1));
        last_pulse = (count_done + CNT_W'(1) == count_lat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort (run_ppt low) takes priority over a pulse ending on the same tick.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (run_ppt) begin
                    state_nxt = cfg_ok ? FIRE : DONE;
                end
            end
            FIRE: begin
                if (!run_ppt) begin
                    state_nxt = IDLE;
                end else if (pulse_end) begin
                    state_nxt = last_pulse ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!run_ppt) begin
                    state_nxt = IDLE;
                end else if (gap_end) begin
                    state_nxt = FIRE;
                end
            end
            DONE: begin
                if (!run_ppt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        latch    = 1'b0;
        clr      = 1'b0;
        fire_nxt = fire;
        cd_nxt   = count_done;
        tc_nxt   = tick_cnt;
        unique case (state)
            IDLE: begin
                if (run_ppt) begin
                    latch  = 1'b1;
                    cd_nxt = '0;
                    tc_nxt = '0;
                    if (cfg_ok) begin
                        clr      = 1'b1;
                        fire_nxt = 1'b1;
                    end
                end
            end
            FIRE: begin
                if (!run_ppt) begin
                    fire_nxt = 1'b0;
                end else if (tick) begin
                    tc_nxt = tick_cnt + CNT_W'(1);
                    if (pulse_end) begin
                        fire_nxt = 1'b0;
                        cd_nxt   = count_done + CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!run_ppt) begin
                    fire_nxt = 1'b0;
                end else if (gap_end) begin
                    tc_nxt   = '0;
                    fire_nxt = 1'b1;
                end else if (tick) begin
                    tc_nxt = tick_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                fire_nxt = 1'b0;
            end
            default: fire_nxt = 1'b0;
        endcase
        busy_nxt = (state_nxt == FIRE) || (state_nxt == WAIT);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count_done <= '0;
            tick_cnt   <= '0;
            div_lat    <= '0;
            period_lat <= '0;
            width_lat  <= '0;
            count_lat  <= '0;
        end else begin
            fire       <= fire_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            count_done <= cd_nxt;
            tick_cnt   <= tc_nxt;
            if (latch) begin
                div_lat    <= clk_div;
                period_lat <= period;
                width_lat  <= width;
                count_lat  <= count;
            end
        end
    end

endmodule

// File: tb/tb_ppt_pulse_controller.sv
// Directed bench for ppt_pulse_controller.
// Durations are counted in clk cycles, sampled on the falling edge.
module tb_ppt_pulse_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  clk_div = '0;
    logic [15:0] period = '0;
    logic [15:0] width = '0;
    logic [15:0] count = '0;
    logic        run_ppt = 1'b0;
    logic        fire;
    logic        busy;
    logic [15:0] count_done;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ppt_pulse_controller dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .period     (period),
        .width      (width),
        .count      (count),
        .run_ppt    (run_ppt),
        .fire       (fire),
        .busy       (busy),
        .count_done (count_done),
        .done       (done)
    );

    task automatic set_cfg(input logic [4:0] d, input logic [15:0] p,
                           input logic [15:0] w, input logic [15:0] c);
        clk_div = d;
        period  = p;
        width   = w;
        count   = c;
    endtask

    task automatic measure(input logic lvl, input int limit, output int n);
        n = 0;
        while (fire === lvl && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic stop_run();
        run_ppt = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run_ppt = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL reset_fire got %b want 0", fire); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (count_done !== 16'd0) begin errors++; $display("FAIL reset_cd got %0d want 0", count_done); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL idle_fire got %b want 0", fire); end
    endtask

    task automatic test_defaults();
        int n;
        set_cfg(5'd9, 16'd128, 16'd1, 16'd16);
        run_ppt = 1'b1;
        @(negedge clk);
        measure(1'b1, 5000, n);
        checks++; if (n !== 1024) begin errors++; $display("FAIL def_high got %0d want 1024", n); end
        checks++; if (count_done !== 16'd1) begin errors++; $display("FAIL def_cd got %0d want 1", count_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL def_busy got %b want 1", busy); end
        stop_run();
    endtask

    task automatic test_basic();
        int n;
        set_cfg(5'd0, 16'd4, 16'd2, 16'd3);
        run_ppt = 1'b1;
        @(negedge clk);
        checks++; if (fire !== 1'b1) begin errors++; $display("FAIL bas_rise got %b want 1", fire); end
        for (int i = 0; i < 3; i++) begin
            measure(1'b1, 50, n);
            checks++; if (n !== 4) begin errors++; $display("FAIL bas_high%0d got %0d want 4", i, n); end
            checks++; if (count_done !== 16'(i + 1)) begin errors++; $display("FAIL bas_cd%0d got %0d want %0d", i, count_done, i + 1); end
            if (i < 2) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL bas_early_done%0d got %b want 0", i, done); end
                measure(1'b0, 50, n);
                checks++; if (n !== 4) begin errors++; $display("FAIL bas_low%0d got %0d want 4", i, n); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bas_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bas_busy got %b want 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1 || fire !== 1'b0) begin errors++; $display("FAIL bas_hold done=%b fire=%b want 1/0", done, fire); end
        run_ppt = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL bas_clear got %b want 0", done); end
        stop_run();
    endtask

    task automatic test_clamp();
        int n;
        set_cfg(5'd0, 16'd3, 16'd5, 16'd2);
        run_ppt = 1'b1;
        @(negedge clk);
        measure(1'b1, 50, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL clp_high got %0d want 4", n); end
        measure(1'b0, 50, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL clp_low got %0d want 2", n); end
        measure(1'b1, 50, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL clp_high2 got %0d want 4", n); end
        checks++; if (done !== 1'b1 || count_done !== 16'd2) begin errors++; $display("FAIL clp_end done=%b cd=%0d want 1/2", done, count_done); end
        stop_run();
    endtask

    task automatic test_invalid();
        logic [15:0] pv [3];
        logic [15:0] wv [3];
        logic [15:0] cv [3];
        logic        seen;
        pv = '{16'd4, 16'd1, 16'd4};
        wv = '{16'd2, 16'd2, 16'd0};
        cv = '{16'd0, 16'd3, 16'd3};
        for (int i = 0; i < 3; i++) begin
            set_cfg(5'd0, pv[i], wv[i], cv[i]);
            run_ppt = 1'b1;
            seen = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (fire !== 1'b0) seen = 1'b1;
            end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL inv%0d_done got %b want 1", i, done); end
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL inv%0d_fire got %b want 0", i, seen); end
            checks++; if (count_done !== 16'd0) begin errors++; $display("FAIL inv%0d_cd got %0d want 0", i, count_done); end
            stop_run();
        end
    endtask

    task automatic test_abort();
        int n;
        set_cfg(5'd0, 16'd4, 16'd2, 16'd4);
        run_ppt = 1'b1;
        @(negedge clk);
        measure(1'b1, 50, n);
        measure(1'b0, 50, n);
        @(negedge clk);
        run_ppt = 1'b0;
        @(negedge clk);
        checks++; if (fire !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abt_out fire=%b busy=%b want 0/0", fire, busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abt_done got %b want 0", done); end
        repeat (6) @(negedge clk);
        checks++; if (count_done !== 16'd1) begin errors++; $display("FAIL abt_cd got %0d want 1", count_done); end
        run_ppt = 1'b1;
        @(negedge clk);
        checks++; if (fire !== 1'b1 || count_done !== 16'd0) begin errors++; $display("FAIL abt_restart fire=%b cd=%0d want 1/0", fire, count_done); end
        measure(1'b1, 50, n);
        checks++; if (n !== 4 || count_done !== 16'd1) begin errors++; $display("FAIL abt_p1 high=%0d cd=%0d want 4/1", n, count_done); end
        measure(1'b0, 50, n);
        repeat (3) @(negedge clk);
        run_ppt = 1'b0;
        @(negedge clk);
        checks++; if (fire !== 1'b0 || count_done !== 16'd1) begin errors++; $display("FAIL abt_sim fire=%b cd=%0d want 0/1", fire, count_done); end
        stop_run();
    endtask

    task automatic test_cfg_rst();
        int n;
        set_cfg(5'd1, 16'd4, 16'd2, 16'd3);
        run_ppt = 1'b1;
        @(negedge clk);
        set_cfg(5'd0, 16'd10, 16'd7, 16'd1);
        measure(1'b1, 100, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL cfg_high got %0d want 8", n); end
        measure(1'b0, 100, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL cfg_low got %0d want 8", n); end
        checks++; if (count_done !== 16'd1 || busy !== 1'b1) begin errors++; $display("FAIL cfg_mid cd=%0d busy=%b want 1/1", count_done, busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_ppt = 1'b0;
        @(negedge clk);
        checks++; if (fire !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_out fire=%b busy=%b want 0/0", fire, busy); end
        checks++; if (done !== 1'b0 || count_done !== 16'd0) begin errors++; $display("FAIL rst_cnt done=%b cd=%0d want 0/0", done, count_done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_basic();
        test_clamp();
        test_invalid();
        test_abort();
        test_cfg_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
